bus_wait: RTL and testbench
===========================

# bus_wait

Memory bus interface and wait-state generator between the address bus generator and external memory.
- Takes the 16-bit address, write enable and write data the core issues each cycle, and drives the external memory strobes.
- Inserts a programmable number of wait states for a slow address region, extends accesses while the memory is not ready, and returns read data on DI.
- Drives RDY back to the core; while RDY is low the core holds AB, WE, DO and its ab_op sequencing.

## Interface

Parameters
- WAIT_BASE, 16'hC000: addresses >= WAIT_BASE form the slow region.
- WAIT_CYCLES, 2: stall cycles for a slow-region access; 0 makes the slow region fast.
- TIMEOUT, 255: maximum cycles spent waiting on mem_ready (used only with BUS_TIMEOUT_EN); must be >= 1.

Ports
- clk  in  1  core clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- AB  in  16  access address from the address bus generator.
- WE  in  1  1 = write, 0 = read.
- DO  in  8  write data from the core.
- REQ  in  1  core issues an access this cycle.
- RDY  out  1  1 = the access completes at this edge; 0 = core holds.
- DI  out  8  registered read data to the core.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write strobe.
- mem_cs  out  1  memory chip select.
- mem_rdata  in  8  memory read data.
- mem_ready  in  1  memory can complete the access this cycle.
- bus_err  out  1  sticky timeout flag.

## Operation

States: IDLE, WAIT.

**Reset (RST_N low)**
- State = IDLE; DI = 8'h00; wait counter = 0; timeout counter = 0; bus_err = 0; address, data and WE latches = 0.
- RDY = 0 and mem_cs = 0 while reset is asserted.
- Reset asserted mid-WAIT abandons the access. DI is not updated.

**IDLE**
- mem_addr = AB, mem_wdata = DO, mem_we = WE & REQ, mem_cs = REQ (combinational pass-through).
- REQ = 0: RDY = 1, DI holds its value, state stays IDLE.
- Fast access (REQ = 1, and either AB < WAIT_BASE or WAIT_CYCLES = 0) with mem_ready = 1: RDY = 1. On a read, DI <= mem_rdata at the edge.
- Otherwise (REQ = 1, slow region or mem_ready = 0):
  - RDY = 0.
  - Latch AB, DO and WE.
  - Load the wait counter with WAIT_CYCLES-1 for a slow access, or 0 for a fast access. Clear the timeout counter.
  - Go to WAIT.

**WAIT**
- Memory outputs are driven from the latches; mem_cs = 1.
- Wait counter != 0: RDY = 0, decrement the counter.
- Wait counter = 0 and mem_ready = 1: RDY = 1. On a read, DI <= mem_rdata. Go to IDLE.
- Wait counter = 0 and mem_ready = 0: RDY = 0, increment the timeout counter.
- Writes never modify DI.
- REQ is ignored in WAIT; the core holds it along with AB.

**Region compare**
- Unsigned 16-bit compare; 16'hFFFF lies in the slow region.

## Timing
- Fast read issued in cycle N: RDY = 1 in N, DI valid from N+1. This is zero-wait operation with DI one cycle after AB.
- Slow access issued in N with mem_ready held 1: RDY is low in exactly WAIT_CYCLES cycles (N to N+WAIT_CYCLES-1) and goes high in N+WAIT_CYCLES. DI is valid from N+WAIT_CYCLES+1.
- Each cycle mem_ready is low once the wait counter reaches 0 extends the stall by one cycle.
- Back-to-back accesses: a new access can be issued in IDLE in the cycle right after a WAIT completion. There is no dead cycle.

## Configuration
- BUS_TIMEOUT_EN defined:
  - When the timeout counter reaches TIMEOUT in WAIT with mem_ready still 0, the access completes anyway: RDY = 1 that cycle, a read sets DI <= 8'hFF, bus_err <= 1, and the state returns to IDLE.
  - bus_err stays 1 until reset.
- BUS_TIMEOUT_EN undefined:
  - WAIT persists for as long as mem_ready is 0.
  - bus_err is constant 0 and the timeout counter is not implemented.

## Test plan
- Reset, then release with REQ = 0 -> DI = 8'h00, RDY = 1, mem_cs = 0, bus_err = 0.
- Read AB = 16'h1234, mem_rdata = 8'hA5, mem_ready = 1 -> RDY stays 1, DI = 8'hA5 the next cycle, mem_addr = 16'h1234.
- Read AB = 16'hC000, WAIT_CYCLES = 2, mem_rdata = 8'h5A -> RDY low 2 cycles, mem_addr held at 16'hC000 throughout, DI = 8'h5A after completion.
- Write AB = 16'hFFFF, DO = 8'h3C, mem_ready low for 3 extra cycles -> RDY low 5 cycles, mem_we = 1 and mem_wdata = 8'h3C throughout, DI unchanged.
- Assert RST_N low in the second WAIT cycle of a slow read -> state IDLE, RDY = 0, mem_cs = 0, DI = 8'h00; after release the next read completes normally.
- With BUS_TIMEOUT_EN and TIMEOUT = 4, read AB = 16'h0010 with mem_ready stuck at 0 -> RDY goes high after 4 WAIT cycles, DI = 8'hFF, bus_err = 1 and stays 1.

Source files
------------

// File: rtl/bus_wait_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait_if
//  Description : Core-side access signals and external memory signals of the
//                bus_wait block. The slave modport is the wait-state
//                generator; the master modport is its environment, which is
//                the core together with the memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_wait_if;
    logic [15:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic        REQ;
    logic        RDY;
    logic [7:0]  DI;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_cs;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    modport slave (
        input  AB, WE, DO, REQ, mem_rdata, mem_ready,
        output RDY, DI, mem_addr, mem_wdata, mem_we, mem_cs, bus_err
    );

    modport master (
        output AB, WE, DO, REQ, mem_rdata, mem_ready,
        input  RDY, DI, mem_addr, mem_wdata, mem_we, mem_cs, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_wait.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait
//  Description : Memory bus interface and wait-state generator. A fast access
//                passes straight through to memory in zero wait states. A
//                slow-region access, or an access the memory cannot complete,
//                is latched and stretched in WAIT until the memory is ready.
//                Optional feature macro: BUS_TIMEOUT_EN. It bounds the time
//                spent waiting on mem_ready and raises a sticky bus_err.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_wait #(
    parameter logic [15:0] WAIT_BASE   = 16'hC000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          TIMEOUT     = 255
) (
    input  wire logic clk,
    input  wire logic RST_N,
    bus_wait_if.slave bus
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    // Reject a zero timeout at elaboration time.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("bus_wait: TIMEOUT must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q,  wcnt_d;
    logic [15:0]    addr_q,  addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           we_q,    we_d;
    logic [7:0]     di_q,    di_d;
    logic           err_q,   err_d;

`ifdef BUS_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tcnt_q, tcnt_d;
`endif

    logic           is_slow;
    logic           rdy;
    logic           cs;
    logic [15:0]    maddr;
    logic [7:0]     mwdata;
    logic           mwe;

    // Next-state, counters, latches and memory strobes.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        di_d    = di_q;
        err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        rdy     = 1'b0;
        cs      = 1'b0;
        maddr   = bus.AB;
        mwdata  = bus.DO;
        mwe     = 1'b0;
        // A zero wait-state count turns the slow region into a fast one.
        is_slow = (bus.AB >= WAIT_BASE) && (WAIT_CYCLES != 0);

        case (state_q)
            ST_IDLE: begin
                cs  = bus.REQ;
                mwe = bus.WE & bus.REQ;
                if (!bus.REQ) begin
                    rdy = 1'b1;
                end else if (!is_slow && bus.mem_ready) begin
                    rdy = 1'b1;
                    if (!bus.WE) begin
                        di_d = bus.mem_rdata;
                    end
                end else begin
                    addr_d  = bus.AB;
                    wdata_d = bus.DO;
                    we_d    = bus.WE;
                    wcnt_d  = is_slow ? WCW'(WAIT_CYCLES - 1) : '0;
`ifdef BUS_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cs     = 1'b1;
                maddr  = addr_q;
                mwdata = wdata_q;
                mwe    = we_q;
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end else if (bus.mem_ready) begin
                    rdy     = 1'b1;
                    if (!we_q) begin
                        di_d = bus.mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tcnt_q == TCW'(TIMEOUT)) begin
                    // Give up on the memory: finish the access with a
                    // poisoned read value and flag the error permanently.
                    rdy     = 1'b1;
                    if (!we_q) begin
                        di_d = 8'hFF;
                    end
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and latches; reset abandons any access in flight.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            di_q    <= 8'h00;
            err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            di_q    <= di_d;
            err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    // RDY and chip select are forced low while reset is held, even though
    // the IDLE path would otherwise pass REQ straight through.
    assign bus.RDY       = rdy & RST_N;
    assign bus.mem_cs    = cs & RST_N;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;
    assign bus.mem_we    = mwe;
    assign bus.DI        = di_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.bus_err   = err_q;
`else
    assign bus.bus_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_wait.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_wait
//  Description : Testbench for bus_wait. Expected read data is queued when an
//                access is issued and compared with DI after the completing
//                edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_wait;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [7:0] model_di;
    logic [7:0] exp_q[$];

    bus_wait_if bif();

    bus_wait #(
        .WAIT_BASE   (16'hC000),
        .WAIT_CYCLES (2),
        .TIMEOUT     (4)
    ) dut (
        .clk   (clk),
        .RST_N (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // A read or write is completing when REQ and RDY are both high; DI is
    // checked against the queued value just after that edge.
    always @(negedge clk) begin
        if (rst_n && bif.REQ && bif.RDY) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                @(posedge clk);
                #2;
                chk("di", {24'd0, bif.DI}, {24'd0, e});
            end
        end
    end

    // Issue one access; mem_ready rises ready_at cycles after issue and RDY
    // is expected low for exactly exp_low cycles.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input logic [7:0] rd, input int ready_at, input int exp_low,
                          input logic to_err);
        int   c;
        logic done;
        if (w) begin
            exp_q.push_back(model_di);
        end else begin
            model_di = to_err ? 8'hFF : rd;
            exp_q.push_back(model_di);
        end
        c    = 0;
        done = 1'b0;
        while (!done && c < 64) begin
            bif.AB        = a;
            bif.WE        = w;
            bif.DO        = d;
            bif.REQ       = 1'b1;
            bif.mem_rdata = rd;
            bif.mem_ready = (c >= ready_at);
            @(negedge clk);
            chk("rdy", {31'd0, bif.RDY}, {31'd0, (c >= exp_low)});
            chk("mem_addr", {16'd0, bif.mem_addr}, {16'd0, a});
            chk("mem_cs", {31'd0, bif.mem_cs}, 32'd1);
            chk("mem_we", {31'd0, bif.mem_we}, {31'd0, w});
            if (w) chk("mem_wdata", {24'd0, bif.mem_wdata}, {24'd0, d});
            done = bif.RDY;
            @(posedge clk);
            #1;
            c++;
        end
        if (!done) chk("rdy_bound", 32'd0, 32'd1);
        bif.REQ       = 1'b0;
        bif.mem_ready = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        model_di = 8'h00;
        rst_n    = 1'b0;
        bif.AB        = 16'h0000;
        bif.WE        = 1'b0;
        bif.DO        = 8'h00;
        bif.REQ       = 1'b1;
        bif.mem_rdata = 8'h00;
        bif.mem_ready = 1'b1;

        // Reset held with REQ high: no RDY and no chip select.
        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'd0, bif.RDY}, 32'd0);
        chk("rst_cs", {31'd0, bif.mem_cs}, 32'd0);
        @(posedge clk);
        #1;
        bif.REQ = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("idle_di", {24'd0, bif.DI}, 32'h00);
        chk("idle_rdy", {31'd0, bif.RDY}, 32'd1);
        chk("idle_cs", {31'd0, bif.mem_cs}, 32'd0);
        chk("idle_err", {31'd0, bif.bus_err}, 32'd0);
        @(posedge clk);
        #1;

        // Fast read, slow read, stretched slow write, fast read that waits
        // on mem_ready, slow write; all back to back.
        access(16'h1234, 1'b0, 8'h00, 8'hA5, 0, 0, 1'b0);
        access(16'hC000, 1'b0, 8'h00, 8'h5A, 0, 2, 1'b0);
        access(16'hFFFF, 1'b1, 8'h3C, 8'h11, 5, 5, 1'b0);
        access(16'h0100, 1'b0, 8'h00, 8'h77, 2, 2, 1'b0);
        access(16'hBFFF, 1'b0, 8'h00, 8'h66, 0, 0, 1'b0);
        access(16'hC001, 1'b1, 8'hE7, 8'h22, 0, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra;
            logic [7:0]  rd;
            ra = 16'($urandom);
            rd = 8'($urandom);
            access(ra, 1'b0, 8'h00, rd, 0, (ra >= 16'hC000) ? 2 : 0, 1'b0);
        end

        // Reset during the second WAIT cycle of a slow read.
        bif.AB        = 16'hC000;
        bif.WE        = 1'b0;
        bif.REQ       = 1'b1;
        bif.mem_ready = 1'b1;
        bif.mem_rdata = 8'h99;
        @(negedge clk);
        chk("rw_rdy0", {31'd0, bif.RDY}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rw_rdy1", {31'd0, bif.RDY}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_rdy", {31'd0, bif.RDY}, 32'd0);
        chk("rw_rst_cs", {31'd0, bif.mem_cs}, 32'd0);
        chk("rw_rst_di", {24'd0, bif.DI}, 32'h00);
        @(posedge clk);
        #1;
        bif.REQ  = 1'b0;
        rst_n    = 1'b1;
        model_di = 8'h00;
        @(negedge clk);
        chk("rw_idle_rdy", {31'd0, bif.RDY}, 32'd1);
        chk("rw_idle_di", {24'd0, bif.DI}, 32'h00);
        @(posedge clk);
        #1;
        access(16'h2000, 1'b0, 8'h00, 8'h3D, 0, 0, 1'b0);
        access(16'hD000, 1'b0, 8'h00, 8'hC3, 0, 2, 1'b0);

`ifdef BUS_TIMEOUT_EN
        // mem_ready stuck low: four WAIT cycles, then forced completion.
        access(16'h0010, 1'b0, 8'h00, 8'h42, 1000, 5, 1'b1);
        @(negedge clk);
        chk("err_set", {31'd0, bif.bus_err}, 32'd1);
        @(posedge clk);
        #1;
        access(16'h0020, 1'b0, 8'h00, 8'h24, 0, 0, 1'b0);
        @(negedge clk);
        chk("err_sticky", {31'd0, bif.bus_err}, 32'd1);
`else
        @(negedge clk);
        chk("err_zero", {31'd0, bif.bus_err}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
